// File: rtl/intc_pkg.sv
// Shared register map and source-mode encodings for the interrupt controller.
// Latency: none (constants only).
// Backpressure: not applicable.
package intc_pkg;

  // Register select values on cfg_addr
  localparam logic [1:0] INTC_MASK = 2'd0;
  localparam logic [1:0] INTC_MODE = 2'd1;
  localparam logic [1:0] INTC_PEND = 2'd2;
  localparam logic [1:0] INTC_INSV = 2'd3;

  // Per-source MODE bit encodings
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag (index 0 is highest priority).
// Latency: purely combinational.
// Backpressure: none; idx is 0 whenever vld is low.
module intc_prio_enc #(
  parameter int N = 6,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         vld,
  output logic [W-1:0] idx
);

  // Scan from the top so the lowest set index is the last one written
  always_comb begin
    vld = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: level/edge latching, mask, in-service preemption; INTC_SYNC_EN adds a 2-flop src synchroniser.
// Latency: src to irq/int_o is 2 cycles (4 with INTC_SYNC_EN); MASK write to irq is 1 cycle after the write edge.
// Backpressure: irq holds until int_ack or until the masked pending bit drops; int_ack with irq low is ignored.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int N_SRC = 6,
  parameter int IDW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             irq,
  output logic [IDW-1:0]   irq_id,
  output logic [N_SRC-1:0] int_o
);

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] src_prev;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] insv;

  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] insv_nxt;
  logic [N_SRC-1:0] wdata;
  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] ack_onehot;
  logic [N_SRC-1:0] eoi_onehot;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] mode_chg;

  logic             we_mask;
  logic             we_mode;
  logic             we_pend;
  logic             ack_fire;
  logic             cand_vld;
  logic [IDW-1:0]   cand_id;
  logic             act_vld;
  logic [IDW-1:0]   act_id;
  logic             irq_nxt;

  // Only the low N_SRC bits of write data carry register content
  logic             unused_wdata;
  assign unused_wdata = ^cfg_wdata;
  assign wdata        = cfg_wdata[N_SRC-1:0];

`ifdef INTC_SYNC_EN
  logic [N_SRC-1:0] sync_q1;
  logic [N_SRC-1:0] sync_q2;

  // Two-flop synchroniser so src may come from another clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= src;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = src;
`endif

  assign we_mask = cfg_we && (cfg_addr == INTC_MASK);
  assign we_mode = cfg_we && (cfg_addr == INTC_MODE);
  assign we_pend = cfg_we && (cfg_addr == INTC_PEND);

  // Ack only counts when a request is actually being presented
  assign ack_fire   = int_ack && irq;
  assign ack_onehot = ack_fire ? (N_SRC'(1) << irq_id) : '0;
  assign eoi_onehot = (eoi && act_vld) ? (N_SRC'(1) << act_id) : '0;

  // eoi retires the active service before the new ack bit lands
  assign insv_nxt = (insv & ~eoi_onehot) | ack_onehot;

  assign edge_set = s & ~src_prev;
  assign w1c      = we_pend ? wdata : '0;
  assign mode_chg = we_mode ? (wdata ^ mode) : '0;

  // Per-bit pending update: level follows the input, edge is sticky with set-over-clear
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode[i] == MODE_EDGE) begin
        pend_nxt[i] = edge_set[i] | (pend[i] & ~(ack_onehot[i] | w1c[i]));
      end else begin
        pend_nxt[i] = s[i];
      end
    end
    // A source being reconfigured starts from a clean pending state
    pend_nxt = pend_nxt & ~mode_chg;
  end

  intc_prio_enc #(.N(N_SRC), .W(IDW)) u_cand (
    .req (pend & mask),
    .vld (cand_vld),
    .idx (cand_id)
  );

  intc_prio_enc #(.N(N_SRC), .W(IDW)) u_act (
    .req (insv),
    .vld (act_vld),
    .idx (act_id)
  );

  // Only a strictly higher-priority (lower index) candidate preempts an active service
  assign irq_nxt = cand_vld && (!act_vld || (cand_id < act_id));

  // Register file, edge history and registered CPU-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_prev <= '0;
      mask     <= '0;
      mode     <= '0;
      pend     <= '0;
      insv     <= '0;
      irq      <= 1'b0;
      irq_id   <= '0;
      int_o    <= '0;
    end else begin
      src_prev <= s;
      pend     <= pend_nxt;
      insv     <= insv_nxt;
      if (we_mask) mask <= wdata;
      if (we_mode) mode <= wdata;
      irq      <= irq_nxt;
      if (cand_vld) irq_id <= cand_id;
      int_o    <= pend & mask;
    end
  end

  // Register readback reflects state before the current edge
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      INTC_MASK: cfg_rdata = 32'(mask);
      INTC_MODE: cfg_rdata = 32'(mode);
      INTC_PEND: cfg_rdata = 32'(pend);
      INTC_INSV: cfg_rdata = 32'(insv);
      default:   cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with an expectation queue drained at sample points.
// Latency: samples on the falling edge, away from the active rising edge.
// Backpressure: not applicable; a watchdog bounds the run.
module tb_int_ctrl;
  import intc_pkg::*;

  localparam int N = 6;
`ifdef INTC_SYNC_EN
  localparam int SYNCD = 2;
`else
  localparam int SYNCD = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  src;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;
  logic          int_ack;
  logic          eoi;
  logic          irq;
  logic [2:0]    irq_id;
  logic [N-1:0]  int_o;

  int checks = 0;
  int errors = 0;

  typedef enum int {K_IRQ, K_ID, K_INTO, K_RD} kind_e;
  kind_e       kind_q[$];
  logic [1:0]  addr_q[$];
  logic [31:0] exp_q[$];
  string       tag_q[$];

  int_ctrl #(.N_SRC(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (src),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .int_ack   (int_ack),
    .eoi       (eoi),
    .irq       (irq),
    .irq_id    (irq_id),
    .int_o     (int_o)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input kind_e k, input logic [1:0] a, input logic [31:0] v, input string tag);
    kind_q.push_back(k);
    addr_q.push_back(a);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    kind_e       k;
    logic [1:0]  a;
    logic [31:0] e;
    logic [31:0] obs;
    string       t;
    while (kind_q.size() > 0) begin
      k = kind_q.pop_front();
      a = addr_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      case (k)
        K_IRQ:   obs = {31'd0, irq};
        K_ID:    obs = 32'(irq_id);
        K_INTO:  obs = 32'(int_o);
        default: begin
          cfg_addr = a;
          #1;
          obs = cfg_rdata;
        end
      endcase
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic pulse_src(input logic [N-1:0] v);
    src = v;
    @(negedge clk);
    src = '0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; src = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    int_ack = 1'b0; eoi = 1'b0;
    tick(3);
    rst_n = 1'b1;

    // Reset state
    expect_val(K_IRQ, 0, 0, "rst_irq");
    expect_val(K_ID, 0, 0, "rst_id");
    expect_val(K_INTO, 0, 0, "rst_into");
    expect_val(K_RD, INTC_MASK, 0, "rst_mask");
    expect_val(K_RD, INTC_MODE, 0, "rst_mode");
    expect_val(K_RD, INTC_PEND, 0, "rst_pend");
    expect_val(K_RD, INTC_INSV, 0, "rst_insv");
    drain();

    // Level source 2: two-cycle latency on assert and deassert
    cfg_write(INTC_MASK, 32'h3F);
    src = 6'h04;
    tick(1 + SYNCD);
    expect_val(K_IRQ, 0, 0, "lvl_irq_early");
    drain();
    tick(1);
    expect_val(K_IRQ, 0, 1, "lvl_irq");
    expect_val(K_ID, 0, 2, "lvl_id");
    expect_val(K_INTO, 0, 32'h04, "lvl_into");
    drain();
    src = '0;
    tick(1 + SYNCD);
    expect_val(K_IRQ, 0, 1, "lvl_irq_hold");
    drain();
    tick(1);
    expect_val(K_IRQ, 0, 0, "lvl_irq_drop");
    expect_val(K_INTO, 0, 0, "lvl_into_drop");
    drain();

    // Edge source 5: pulse latches, ack moves it to in-service
    cfg_write(INTC_MODE, 32'h3F);
    pulse_src(6'h20);
    tick(SYNCD);
    expect_val(K_RD, INTC_PEND, 32'h20, "edge_pend");
    drain();
    tick(1);
    expect_val(K_IRQ, 0, 1, "edge_irq");
    expect_val(K_ID, 0, 5, "edge_id");
    drain();
    tick(2);
    expect_val(K_RD, INTC_PEND, 32'h20, "edge_pend_held");
    expect_val(K_IRQ, 0, 1, "edge_irq_held");
    drain();
    pulse_ack();
    tick(1);
    expect_val(K_RD, INTC_INSV, 32'h20, "ack_insv");
    expect_val(K_RD, INTC_PEND, 0, "ack_pend_clr");
    expect_val(K_IRQ, 0, 0, "ack_irq");
    drain();
    pulse_eoi();
    expect_val(K_RD, INTC_INSV, 0, "eoi_insv");
    drain();

    // Nesting: 3 in service, 4 blocked, 1 preempts
    pulse_src(6'h08);
    tick(SYNCD + 1);
    expect_val(K_IRQ, 0, 1, "nest3_irq");
    expect_val(K_ID, 0, 3, "nest3_id");
    drain();
    pulse_ack();
    tick(1);
    expect_val(K_RD, INTC_INSV, 32'h08, "nest3_insv");
    expect_val(K_IRQ, 0, 0, "nest3_irq_off");
    drain();
    pulse_src(6'h10);
    tick(SYNCD + 2);
    expect_val(K_IRQ, 0, 0, "nest4_blocked");
    expect_val(K_RD, INTC_PEND, 32'h10, "nest4_pend");
    drain();
    pulse_src(6'h02);
    tick(SYNCD + 1);
    expect_val(K_IRQ, 0, 1, "nest1_irq");
    expect_val(K_ID, 0, 1, "nest1_id");
    drain();
    pulse_ack();
    tick(1);
    expect_val(K_RD, INTC_INSV, 32'h0A, "nest1_insv");
    expect_val(K_IRQ, 0, 0, "nest1_irq_off");
    expect_val(K_RD, INTC_PEND, 32'h10, "nest1_pend");
    drain();
    pulse_eoi();
    expect_val(K_RD, INTC_INSV, 32'h08, "eoi1_insv");
    drain();
    tick(1);
    expect_val(K_IRQ, 0, 0, "eoi1_irq");
    drain();
    pulse_eoi();
    expect_val(K_RD, INTC_INSV, 0, "eoi2_insv");
    drain();
    tick(1);
    expect_val(K_IRQ, 0, 1, "eoi2_irq4");
    expect_val(K_ID, 0, 4, "eoi2_id4");
    drain();
    pulse_ack();
    pulse_eoi();
    expect_val(K_RD, INTC_INSV, 0, "clean_insv");
    expect_val(K_RD, INTC_PEND, 0, "clean_pend");
    drain();
    tick(1);
    expect_val(K_IRQ, 0, 0, "clean_irq");
    drain();

    // Edge detect coincident with W1C of the same bit: set wins
    src = 6'h01;
    repeat (SYNCD) begin
      @(negedge clk);
      src = '0;
    end
    cfg_we = 1'b1; cfg_addr = INTC_PEND; cfg_wdata = 32'h1;
    @(negedge clk);
    src = '0; cfg_we = 1'b0; cfg_wdata = '0;
    expect_val(K_RD, INTC_PEND, 32'h01, "set_beats_w1c");
    drain();
    cfg_write(INTC_PEND, 32'h1);
    tick(1);
    expect_val(K_RD, INTC_PEND, 0, "w1c_clear");
    expect_val(K_IRQ, 0, 0, "w1c_irq");
    drain();

    // Pending latches while masked; unmask takes one cycle
    cfg_write(INTC_MASK, 32'h0);
    pulse_src(6'h04);
    tick(SYNCD + 1);
    expect_val(K_RD, INTC_PEND, 32'h04, "masked_pend");
    expect_val(K_IRQ, 0, 0, "masked_irq");
    expect_val(K_INTO, 0, 0, "masked_into");
    drain();
    cfg_write(INTC_MASK, 32'h04);
    expect_val(K_IRQ, 0, 0, "unmask_early");
    drain();
    tick(1);
    expect_val(K_IRQ, 0, 1, "unmask_irq");
    expect_val(K_ID, 0, 2, "unmask_id");
    expect_val(K_INTO, 0, 32'h04, "unmask_into");
    drain();

    // Asynchronous reset while servicing with irq high
    pulse_ack();
    tick(1);
    cfg_write(INTC_MASK, 32'h3F);
    pulse_src(6'h01);
    tick(SYNCD + 1);
    expect_val(K_IRQ, 0, 1, "pre_rst_irq");
    expect_val(K_ID, 0, 0, "pre_rst_id");
    expect_val(K_RD, INTC_INSV, 32'h04, "pre_rst_insv");
    drain();
    #1 rst_n = 1'b0;
    #1;
    expect_val(K_IRQ, 0, 0, "arst_irq");
    expect_val(K_ID, 0, 0, "arst_id");
    expect_val(K_INTO, 0, 0, "arst_into");
    expect_val(K_RD, INTC_INSV, 0, "arst_insv");
    expect_val(K_RD, INTC_PEND, 0, "arst_pend");
    expect_val(K_RD, INTC_MASK, 0, "arst_mask");
    expect_val(K_RD, INTC_MODE, 0, "arst_mode");
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    expect_val(K_IRQ, 0, 0, "post_rst_irq");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
